// File: rtl/ext_bus_slave_regfile.sv
// Register-file target for the external-bus bridge: programmable ack latency,
// abort on early bus_enable drop, byte-lane writes and a sticky, maskable IRQ block.
module ext_bus_slave_regfile #(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned IRQ_W       = 4,
    parameter logic [15:0] ID_VALUE    = 16'hC561
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset_n,
    input  logic                             bus_enable,
    input  logic                             rw,
    input  logic [ADDR_W-1:0]                address,
    input  logic [DATA_W/8-1:0]              byte_enable,
    input  logic [DATA_W-1:0]                write_data,
    output logic [DATA_W-1:0]                read_data,
    output logic                             acknowledge,
    output logic                             irq,
    input  logic [IRQ_W-1:0]                 irq_event,
    output logic [(NUM_REGS-3)*DATA_W-1:0]   ctrl_regs
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(BE_W);
    localparam int unsigned IDX_W = ADDR_W - LSB;
    localparam int unsigned NCTRL = NUM_REGS - 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_GAP} state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         rw_q, rw_d;
    logic [BE_W-1:0]              be_q, be_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic                         ack_q, ack_d;
    logic [DATA_W-1:0]            rdata_q, rdata_d;
    logic                         irq_q, irq_d;
    logic [IRQ_W-1:0]             status_q, status_d;
    logic [IRQ_W-1:0]             mask_q, mask_d;
    logic [NCTRL-1:0][DATA_W-1:0] ctrl_q, ctrl_d;

    logic [IDX_W-1:0]             rd_idx;
    logic [DATA_W-1:0]            rd_val;
    logic [DATA_W-1:0]            lane_mask;
    logic [IRQ_W-1:0]             irq_clr;
    logic                         commit;
    logic                         unused_addr_lsbs;

    assign unused_addr_lsbs = ^address[LSB-1:0];

    // Read mux: live address when accepting with zero wait states, captured index otherwise
    always_comb begin
        rd_idx = (state_q == S_IDLE) ? address[ADDR_W-1:LSB] : idx_q;
        rd_val = '0;
        if (rd_idx == IDX_W'(0)) rd_val = DATA_W'(ID_VALUE);
        if (rd_idx == IDX_W'(1)) rd_val = DATA_W'(status_q);
        if (rd_idx == IDX_W'(2)) rd_val = DATA_W'(mask_q);
        for (int i = 0; i < NCTRL; i++) begin
            if (rd_idx == IDX_W'(i + 3)) rd_val = ctrl_q[i];
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            lane_mask[b*8 +: 8] = {8{be_q[b]}};
        end
    end

    // Transaction sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_enable) begin
                    idx_d   = address[ADDR_W-1:LSB];
                    rw_d    = rw;
                    be_d    = byte_enable;
                    wdata_d = write_data;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rdata_d = rw ? rd_val : '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus_enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    rdata_d = rw_q ? rd_val : '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_GAP;
                commit  = !rw_q;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register commits and interrupt status; a same-edge event beats a clear
    always_comb begin
        mask_d  = mask_q;
        ctrl_d  = ctrl_q;
        irq_clr = '0;
        if (commit) begin
            if (idx_q == IDX_W'(1)) irq_clr = wdata_q[IRQ_W-1:0] & lane_mask[IRQ_W-1:0];
            if (idx_q == IDX_W'(2)) begin
                mask_d = (mask_q & ~lane_mask[IRQ_W-1:0]) |
                         (wdata_q[IRQ_W-1:0] & lane_mask[IRQ_W-1:0]);
            end
            for (int i = 0; i < NCTRL; i++) begin
                if (idx_q == IDX_W'(i + 3)) ctrl_d[i] = (ctrl_q[i] & ~lane_mask) | (wdata_q & lane_mask);
            end
        end
        status_d = (status_q & ~irq_clr) | irq_event;
        irq_d    = |(status_d & mask_d);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            rw_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            status_q <= '0;
            mask_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rw_q     <= rw_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign read_data   = rdata_q;
    assign acknowledge = ack_q;
    assign irq         = irq_q;
    assign ctrl_regs   = ctrl_q;

endmodule
